// File: rtl/roberto_escalonador.sv
// Sequences three ultrasonic sensors over one shared measurement interface and frames each result
// as ASCII for the serial transmitter. Define ROBERTO_ESC_CHECKSUM_EN to append a per-round XOR checksum char.
module roberto_escalonador #(
  parameter int TIMEOUT_CYCLES   = 2_500_000,
  parameter int INTERVALO_CYCLES = 50_000_000,
  parameter int CNT_W            = 26
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ligar,
  input  logic        continuo,
  input  logic [2:0]  mascara,
  output logic [1:0]  sel_sensor,
  output logic        medir,
  input  logic        pronto_medida,
  input  logic [11:0] medida,
  output logic        partida_tx,
  output logic [6:0]  dado_tx,
  input  logic        pronto_tx,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'h0,
    S_PREP      = 4'h1,
    S_MEDIR     = 4'h2,
    S_ESPERA    = 4'h3,
    S_CARREGA   = 4'h4,
    S_TX_INI    = 4'h5,
    S_TX_ESP    = 4'h6,
    S_PROX      = 4'h7,
    S_CHECK     = 4'h8,
    S_INTERVALO = 4'h9,
    S_FIM       = 4'hA
  } estado_t;

  localparam logic [CNT_W-1:0] TIMEOUT_FIM   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INTERVALO_FIM = CNT_W'(INTERVALO_CYCLES - 1);

  estado_t          estado;
  logic [CNT_W-1:0] contador;
  logic [2:0]       mascara_q;
  logic [2:0]       acima;
  logic [11:0]      medida_q;
  logic             erro_q;
  logic [2:0]       k;
  logic [2:0]       k_prox;
  logic [6:0]       quadro      [5];
  logic [6:0]       quadro_novo [5];

  function automatic logic [1:0] menor_bit(input logic [2:0] m);
    logic [1:0] r;
    r = 2'd2;
    if (m[1]) r = 2'd1;
    if (m[0]) r = 2'd0;
    return r;
  endfunction

  function automatic logic [6:0] ascii_digito(input logic [3:0] d, input logic erro);
    return (erro || d > 4'd9) ? 7'h45 : {3'b011, d};
  endfunction

  assign db_estado = estado;
  assign k_prox    = k + 3'd1;

  // NOTE: every output of this block gets a value on every path (case default included), so no latch is inferred.
  always_comb begin
    case (sel_sensor)
      2'd0:    acima = mascara_q & 3'b110;
      2'd1:    acima = mascara_q & 3'b100;
      default: acima = 3'b000;
    endcase
    quadro_novo[0] = 7'h41 + {5'd0, sel_sensor};
    quadro_novo[1] = ascii_digito(medida_q[11:8], erro_q);
    quadro_novo[2] = ascii_digito(medida_q[7:4], erro_q);
    quadro_novo[3] = ascii_digito(medida_q[3:0], erro_q);
    quadro_novo[4] = 7'h23;
  end

  // NOTE: the frame buffer has no reset; all five slots are written in CARREGA before TX reads any of them.
  always_ff @(posedge clock) begin
    if (estado == S_CARREGA) quadro <= quadro_novo;
  end

`ifdef ROBERTO_ESC_CHECKSUM_EN
  // Running XOR of every character launched in the current round.
  logic [6:0] soma;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                           soma <= '0;
    else if (estado == S_IDLE || estado == S_INTERVALO)  soma <= '0;
    else if (estado == S_TX_INI)                         soma <= soma ^ dado_tx;
  end
`endif

  // NOTE: state and registered outputs use non-blocking assignments so every read sees the pre-edge value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= S_IDLE;
      sel_sensor <= '0;
      medir      <= 1'b0;
      partida_tx <= 1'b0;
      dado_tx    <= '0;
      pronto     <= 1'b0;
      contador   <= '0;
      mascara_q  <= '0;
      medida_q   <= '0;
      erro_q     <= 1'b0;
      k          <= '0;
    end else begin
      medir      <= 1'b0;
      partida_tx <= 1'b0;
      pronto     <= 1'b0;
      case (estado)
        S_IDLE: if (ligar) begin
          mascara_q <= mascara;
          if (mascara == 3'b000) begin
            pronto <= 1'b1;
            estado <= S_FIM;
          end else begin
            sel_sensor <= menor_bit(mascara);
            estado     <= S_PREP;
          end
        end
        S_PREP: begin
          medir  <= 1'b1;
          estado <= S_MEDIR;
        end
        S_MEDIR: begin
          contador <= '0;
          estado   <= S_ESPERA;
        end
        S_ESPERA: begin
          if (pronto_medida) begin
            medida_q <= medida;
            erro_q   <= 1'b0;
            estado   <= S_CARREGA;
          end else if (contador == TIMEOUT_FIM) begin
            erro_q <= 1'b1;
            estado <= S_CARREGA;
          end else begin
            contador <= contador + 1'b1;
          end
        end
        S_CARREGA: begin
          k          <= '0;
          dado_tx    <= quadro_novo[0];
          partida_tx <= 1'b1;
          estado     <= S_TX_INI;
        end
        S_TX_INI: estado <= S_TX_ESP;
        S_TX_ESP: if (pronto_tx) begin
          if (k == 3'd4) begin
            estado <= S_PROX;
          end else begin
            k          <= k_prox;
            dado_tx    <= quadro[k_prox];
            partida_tx <= 1'b1;
            estado     <= S_TX_INI;
          end
        end
        S_PROX: begin
          if (acima != 3'b000) begin
            sel_sensor <= menor_bit(acima);
            estado     <= S_PREP;
          end else begin
`ifdef ROBERTO_ESC_CHECKSUM_EN
            dado_tx    <= soma | 7'h40;
            partida_tx <= 1'b1;
            estado     <= S_CHECK;
`else
            contador <= '0;
            estado   <= S_INTERVALO;
`endif
          end
        end
`ifdef ROBERTO_ESC_CHECKSUM_EN
        S_CHECK: if (pronto_tx) begin
          contador <= '0;
          estado   <= S_INTERVALO;
        end
`endif
        S_INTERVALO: begin
          if (!continuo) begin
            pronto <= 1'b1;
            estado <= S_FIM;
          end else if (contador == INTERVALO_FIM) begin
            mascara_q <= mascara;
            if (mascara == 3'b000) begin
              pronto <= 1'b1;
              estado <= S_FIM;
            end else begin
              sel_sensor <= menor_bit(mascara);
              estado     <= S_PREP;
            end
          end else begin
            contador <= contador + 1'b1;
          end
        end
        S_FIM:   estado <= S_IDLE;
        default: estado <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_roberto_escalonador.sv
// Table-driven bench for roberto_escalonador with a sensor model, a UART model and a char scoreboard.
module tb_roberto_escalonador;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ligar = 1'b0;
  logic        continuo = 1'b0;
  logic [2:0]  mascara = 3'b000;
  logic [1:0]  sel_sensor;
  logic        medir;
  logic        pronto_medida = 1'b0;
  logic [11:0] medida = 12'h000;
  logic        partida_tx;
  logic [6:0]  dado_tx;
  logic        pronto_tx = 1'b0;
  logic        pronto;
  logic [3:0]  db_estado;

  roberto_escalonador #(
    .TIMEOUT_CYCLES  (TO),
    .INTERVALO_CYCLES(10),
    .CNT_W           (26)
  ) dut (
    .clock        (clk),
    .reset        (rst),
    .ligar        (ligar),
    .continuo     (continuo),
    .mascara      (mascara),
    .sel_sensor   (sel_sensor),
    .medir        (medir),
    .pronto_medida(pronto_medida),
    .medida       (medida),
    .partida_tx   (partida_tx),
    .dado_tx      (dado_tx),
    .pronto_tx    (pronto_tx),
    .pronto       (pronto),
    .db_estado    (db_estado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  mascara;
    logic [11:0] v0, v1, v2;
    logic [2:0]  ans;
    int          delay;
    int          exp_medir;
    int          sel_exp;
  } vec_t;

  int tests = 0, fails = 0;
  int n_medir = 0, n_pronto = 0, overlap = 0, pronto_bad = 0, sel_bad = 0;
  int sens_cnt = 0, tx_cnt = 0, sens_delay = 5;
  logic        sel_watch = 1'b0;
  logic [1:0]  sel_exp = 2'd0;
  logic [11:0] sens_val [3];
  logic [2:0]  sens_ans = 3'b000;
  logic [6:0]  tx_held = 7'h00;
  logic [6:0]  exp_c;
  logic [6:0]  exp_q [$];

  task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, got, exp);
    end
  endtask

  // Sensor answers sens_delay cycles after medir; UART acknowledges 3 cycles after partida_tx.
  always @(negedge clk) begin
    if (rst) begin
      pronto_medida = 1'b0;
      pronto_tx     = 1'b0;
      sens_cnt      = 0;
      tx_cnt        = 0;
      exp_q.delete();
    end else begin
      pronto_medida = 1'b0;
      if (sens_cnt > 0) begin
        sens_cnt--;
        if (sens_cnt == 0) begin
          pronto_medida = 1'b1;
          medida        = sens_val[sel_sensor];
        end
      end
      if (medir) begin
        n_medir++;
        if (sens_ans[sel_sensor]) sens_cnt = sens_delay;
      end
      pronto_tx = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          pronto_tx = 1'b1;
          check("dado_tx_hold", dado_tx, tx_held);
        end
      end
      if (partida_tx) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tx: got char 0x%0h, expected no char", dado_tx);
        end else begin
          exp_c = exp_q.pop_front();
          check("tx_char", dado_tx, exp_c);
        end
        tx_held = dado_tx;
        tx_cnt  = 3;
      end
      if (medir && partida_tx) overlap++;
      if (pronto) begin
        n_pronto++;
        if (db_estado != 4'hA) pronto_bad++;
      end
      if (sel_watch && db_estado >= 4'h1 && db_estado <= 4'h7 && sel_sensor != sel_exp) sel_bad++;
    end
  end

  task automatic push_round(input logic [2:0] m);
    logic [6:0] c [5];
    logic [6:0] x;
    logic [3:0] dg;
    bit ok;
    x = 7'h00;
    for (int i = 0; i < 3; i++) begin
      if (m[i]) begin
        ok   = sens_ans[i] && (sens_delay <= TO);
        c[0] = 7'h41 + 7'(i);
        c[4] = 7'h23;
        for (int d = 0; d < 3; d++) begin
          dg       = sens_val[i][11-4*d -: 4];
          c[1 + d] = (!ok || dg > 4'd9) ? 7'h45 : (7'h30 + {3'b000, dg});
        end
        for (int j = 0; j < 5; j++) begin
          exp_q.push_back(c[j]);
          x = x ^ c[j];
        end
      end
    end
`ifdef ROBERTO_ESC_CHECKSUM_EN
    if (m != 3'b000) exp_q.push_back(x | 7'h40);
`endif
  endtask

  task automatic start_round(input logic [2:0] m);
    mascara = m;
    push_round(m);
    ligar = 1'b1;
    @(negedge clk);
    ligar = 1'b0;
  endtask

  task automatic wait_state(input logic [3:0] st, input int budget, input string nome);
    int n;
    n = 0;
    while (db_estado !== st && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(nome, db_estado, st);
  endtask

  function automatic vec_t mk(input logic [2:0] m, input logic [11:0] a, input logic [11:0] b,
                              input logic [11:0] c, input logic [2:0] ans, input int dl,
                              input int em, input int se);
    vec_t v;
    v.mascara = m; v.v0 = a; v.v1 = b; v.v2 = c;
    v.ans = ans; v.delay = dl; v.exp_medir = em; v.sel_exp = se;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t v [6];
    int m0, p0, lat, gap;

    v[0] = mk(3'b111, 12'h123, 12'h045, 12'h999, 3'b111, 5,  3, -1);
    v[1] = mk(3'b010, 12'h000, 12'h000, 12'h000, 3'b000, 5,  1,  1);
    v[2] = mk(3'b000, 12'h000, 12'h000, 12'h000, 3'b111, 5,  0, -1);
    v[3] = mk(3'b001, 12'h007, 12'h000, 12'h000, 3'b001, TO, 1,  0);
    v[4] = mk(3'b101, 12'h0A5, 12'h000, 12'h3F0, 3'b101, 3,  2, -1);
    v[5] = mk(3'b100, 12'h000, 12'h000, 12'h888, 3'b100, TO + 1, 1, 2);

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_sel_sensor", sel_sensor, 0);
    check("rst_medir", medir, 0);
    check("rst_partida_tx", partida_tx, 0);
    check("rst_dado_tx", dado_tx, 0);
    check("rst_pronto", pronto, 0);
    check("rst_db_estado", db_estado, 0);

    // ligar to medir latency
    sens_val[0] = 12'h321; sens_ans = 3'b001; sens_delay = 5;
    mascara = 3'b001;
    push_round(3'b001);
    ligar = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      ligar = 1'b0;
      lat++;
    end while (!medir && lat < 10);
    check("ligar_to_medir", lat, 2);
    wait_state(4'h0, 2000, "lat_round_end");
    check("lat_queue_drained", exp_q.size(), 0);

    for (int i = 0; i < 6; i++) begin
      sens_val[0] = v[i].v0; sens_val[1] = v[i].v1; sens_val[2] = v[i].v2;
      sens_ans = v[i].ans; sens_delay = v[i].delay;
      m0 = n_medir; p0 = n_pronto; sel_bad = 0;
      sel_watch = (v[i].sel_exp >= 0);
      sel_exp = 2'(v[i].sel_exp);
      start_round(v[i].mascara);
      wait_state(4'h0, 3000, "vec_round_end");
      check("vec_medir_count", n_medir - m0, v[i].exp_medir);
      check("vec_pronto_count", n_pronto - p0, 1);
      check("vec_queue_drained", exp_q.size(), 0);
      if (sel_watch) check("vec_sel_held", sel_bad, 0);
      sel_watch = 1'b0;
      repeat (3) @(negedge clk);
    end

    // ligar and mascara changes mid-round are ignored
    sens_val[0] = 12'h246; sens_ans = 3'b111; sens_delay = 8;
    m0 = n_medir;
    start_round(3'b001);
    wait_state(4'h3, 200, "busy_espera");
    mascara = 3'b111;
    ligar = 1'b1;
    @(negedge clk);
    ligar = 1'b0;
    wait_state(4'h0, 2000, "busy_round_end");
    check("busy_medir_count", n_medir - m0, 1);
    check("busy_queue_drained", exp_q.size(), 0);

    // continuous rounds, then reset in TX_ESP
    sens_val[0] = 12'h456; sens_ans = 3'b001; sens_delay = 5;
    continuo = 1'b1;
    start_round(3'b001);
    push_round(3'b001);
    wait_state(4'h9, 1000, "cont_intervalo");
    gap = 0;
    while (db_estado == 4'h9 && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    check("cont_gap_ge10", gap >= 10, 1);
    check("cont_restart_prep", db_estado, 4'h1);
    wait_state(4'h6, 500, "cont_tx_esp");
    rst = 1'b1;
    continuo = 1'b0;
    @(negedge clk);
    check("mid_rst_sel_sensor", sel_sensor, 0);
    check("mid_rst_medir", medir, 0);
    check("mid_rst_partida_tx", partida_tx, 0);
    check("mid_rst_dado_tx", dado_tx, 0);
    check("mid_rst_pronto", pronto, 0);
    check("mid_rst_db_estado", db_estado, 0);
    rst = 1'b0;
    m0 = n_medir;
    repeat (5) @(negedge clk);
    check("post_rst_idle", db_estado, 0);
    check("post_rst_no_medir", n_medir - m0, 0);

    check("medir_tx_overlap", overlap, 0);
    check("pronto_only_in_fim", pronto_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
